// File: rtl/mul_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mul_seq_ctrl
// Description : Iterative shift-add MUL sequencer for the EX stage; freezes
//               the pipeline while the product is accumulated.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_seq_ctrl #(
    parameter int          WIDTH    = 32,
    parameter int          BPC      = 1,
    parameter logic [3:0]  MUL_CTRL = 4'b0101
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [3:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int                N_STEPS = WIDTH / BPC;
    localparam int                CNT_W   = $clog2(N_STEPS + 1);
    localparam logic [CNT_W-1:0]  C_LAST  = CNT_W'(N_STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   acc_q,    acc_d;
    logic [WIDTH-1:0]   mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               done_q,   done_d;

    logic               w_req;
    logic [WIDTH-1:0]   w_partial;
    logic [WIDTH-1:0]   w_sum;

    assign w_req = valid_i && (ALUCtrl_i == MUL_CTRL);

    // Partial product of the multiplicand with the low BPC multiplier bits.
    always_comb begin
        w_partial = '0;
        for (int i = 0; i < BPC; i++) begin
            if (mplier_q[i]) begin
                w_partial = w_partial + (mcand_q << i);
            end
        end
    end

    assign w_sum = acc_q + w_partial;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_req && !flush_i) begin
                    mcand_d  = data1_i;
                    mplier_d = data2_i;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d    = w_sum;
                    mcand_d  = mcand_q << BPC;
                    mplier_d = mplier_q >> BPC;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == C_LAST) begin
                        result_d = w_sum;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // The frozen MUL retires this cycle, so it is never relaunched.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign stall_o  = !rst_i && !flush_i &&
                      (((state_q == S_IDLE) && w_req) || (state_q == S_BUSY));
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mul_seq_ctrl
// Description : Self-checking bench for mul_seq_ctrl (vector table + random).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_seq_ctrl;

    localparam logic [3:0] C_MUL = 4'b0101;
    localparam logic [3:0] C_ADD = 4'b0011;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [3:0]  alu_ctrl;
    logic [31:0] d1, d2;
    logic        flush;
    logic        stall, done;
    logic [31:0] result;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_result;

    mul_seq_ctrl #(.WIDTH(32), .BPC(1), .MUL_CTRL(C_MUL)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .valid_i   (valid),
        .ALUCtrl_i (alu_ctrl),
        .data1_i   (d1),
        .data2_i   (d2),
        .flush_i   (flush),
        .stall_o   (stall),
        .done_o    (done),
        .result_o  (result)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          b2b;
        bit          flush_done;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_outs(input string nm, input logic s, input logic d, input logic [31:0] r);
        @(negedge clk);
        check({nm, " stall"},  {31'b0, stall}, {31'b0, s});
        check({nm, " done"},   {31'b0, done},  {31'b0, d});
        check({nm, " result"}, result, r);
    endtask

    // A non-MUL instruction in EX: nothing stalls, result holds.
    task automatic idle_cycle();
        step();
        valid = 1'b1; alu_ctrl = C_ADD; flush = 1'b0;
        d1 = $urandom; d2 = $urandom;
        expect_outs("idle", 1'b0, 1'b0, last_result);
    endtask

    // Launch on cycle 1, stall through 33, done with product on 34.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input bit flush_done);
        step();
        valid = 1'b1; alu_ctrl = C_MUL; d1 = a; d2 = b; flush = 1'b0;
        expect_outs("launch", 1'b1, 1'b0, last_result);
        for (int c = 2; c <= 33; c++) begin
            step();
            alu_ctrl = 4'($urandom); d1 = $urandom; d2 = $urandom;
            expect_outs("busy", 1'b1, 1'b0, last_result);
        end
        step();
        alu_ctrl = C_MUL; d1 = a; d2 = b; flush = flush_done;
        expect_outs("done", 1'b0, 1'b1, exp);
        last_result = exp;
    endtask

    vec_t vecs[6];

    initial begin
        logic [63:0] prod;
        logic [31:0] ra, rb;

        vecs[0] = '{32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b0};
        vecs[1] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0};
        vecs[2] = '{32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 1'b0, 1'b0};
        vecs[3] = '{32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1};
        vecs[5] = '{32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};

        rst = 1'b1; valid = 1'b1; alu_ctrl = C_ADD; d1 = '0; d2 = '0; flush = 1'b0;
        last_result = '0;
        expect_outs("reset", 1'b0, 1'b0, 32'h0);
        #1;
        alu_ctrl = C_MUL;
        expect_outs("reset_mul_req", 1'b0, 1'b0, 32'h0);
        step();
        rst = 1'b0; alu_ctrl = C_ADD;
        expect_outs("after_reset_add", 1'b0, 1'b0, 32'h0);
        idle_cycle();

        for (int i = 0; i < 6; i++) begin
            if (!vecs[i].b2b) idle_cycle();
            run_mul(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].flush_done);
        end
        idle_cycle();
        idle_cycle();

        // Give result_o a nonzero value before the flush/reset cases.
        run_mul(32'h0000_0006, 32'h0000_0007, 32'h0000_002A, 1'b0);

        // Flush on overall cycle 10 (a BUSY cycle).
        step();
        valid = 1'b1; alu_ctrl = C_MUL; d1 = 32'h1234_5678; d2 = 32'h0000_0100; flush = 1'b0;
        expect_outs("flush_launch", 1'b1, 1'b0, last_result);
        for (int c = 2; c <= 9; c++) begin
            step();
            expect_outs("flush_busy", 1'b1, 1'b0, last_result);
        end
        step();
        flush = 1'b1;
        expect_outs("flush_cycle", 1'b0, 1'b0, last_result);
        step();
        flush = 1'b0; valid = 1'b0;
        expect_outs("flush_next", 1'b0, 1'b0, last_result);

        // Flushed request while idle must not launch.
        step();
        valid = 1'b1; alu_ctrl = C_MUL; flush = 1'b1;
        expect_outs("flush_idle_req", 1'b0, 1'b0, last_result);
        for (int c = 0; c < 36; c++) begin
            step();
            valid = 1'b0; flush = 1'b0;
            expect_outs("flush_quiet", 1'b0, 1'b0, last_result);
        end
        run_mul(32'h0000_0011, 32'h0000_0003, 32'h0000_0033, 1'b0);
        idle_cycle();

        // Asynchronous reset on overall cycle 20 (a BUSY cycle).
        step();
        valid = 1'b1; alu_ctrl = C_MUL; d1 = 32'h0000_0009; d2 = 32'h0000_0009;
        expect_outs("rst_launch", 1'b1, 1'b0, last_result);
        for (int c = 2; c <= 19; c++) begin
            step();
            expect_outs("rst_busy", 1'b1, 1'b0, last_result);
        end
        step();
        rst = 1'b1;
        last_result = '0;
        expect_outs("rst_mid_busy", 1'b0, 1'b0, 32'h0);
        step();
        rst = 1'b0; valid = 1'b0;
        expect_outs("rst_release", 1'b0, 1'b0, 32'h0);
        run_mul(32'h0000_0002, 32'h0000_0002, 32'h0000_0004, 1'b0);

        // Random operands against plain 64-bit arithmetic, low half kept.
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 0) rb = rb | 32'h8000_0000;
            prod = {32'h0, ra} * {32'h0, rb};
            if ($urandom_range(0, 1) == 1) idle_cycle();
            run_mul(ra, rb, prod[31:0], 1'b0);
        end
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
